// File: rtl/adc_capture_pkg.sv
// Shared types for the adc_capture snapshot block.
//   cap_state_t : capture controller states
//   frame_t     : one sample frame {adc8, adc4, adc2, adc1}, signed 16-bit lanes
//   HDR_MAGIC   : upper 16 bits of the optional timestamp header word
//   sel_ch()    : picks the trigger channel out of a frame
package adc_capture_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPrefill,
    StWaitTrig,
    StPost,
    StReadout
  } cap_state_t;

  typedef struct packed {
    logic signed [15:0] ch8;
    logic signed [15:0] ch4;
    logic signed [15:0] ch2;
    logic signed [15:0] ch1;
  } frame_t;

  localparam logic [15:0] HDR_MAGIC = 16'hA5C0;

  // Channel encoding: 0=adc1 1=adc2 2=adc4 3=adc8
  function automatic logic signed [15:0] sel_ch(input frame_t f, input logic [1:0] ch);
    logic signed [15:0] s;
    unique case (ch)
      2'd0:    s = f.ch1;
      2'd1:    s = f.ch2;
      2'd2:    s = f.ch4;
      default: s = f.ch8;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/adc_capture_ram.sv
// Simple dual-port snapshot buffer: synchronous write, registered read.
// The read register only updates when re_i is high, so it doubles as a
// holding stage for the readout pipeline.
//   clk_i   : clock
//   we_i    : write enable, waddr_i / wdata_i : write port
//   re_i    : read enable,  raddr_i           : read address
//   rdata_o : read data, valid the cycle after re_i
module capture_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // No reset: keeps the array mappable onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_capture.sv
// Triggered snapshot capture of the four deserialised ADC channels.
// Keeps a circular pre-trigger history, triggers on a signed rising threshold
// crossing (or force_trig), records the post-trigger frames, then streams the
// DEPTH-frame snapshot out over valid/ready in buffer-address order.
// Optional feature macro: ADC_CAPTURE_TIMESTAMP_EN adds a 48-bit aligned-cycle
// counter and a leading header word {HDR_MAGIC, counter at trigger frame}.
// Ports:
//   CLKDIV, RST            : clock, asynchronous active-high reset
//   aligned                : input frames valid while high
//   adc1/adc2/adc4/adc8    : signed channel samples
//   arm, abort, force_trig : control pulses
//   trig_ch, trig_lvl      : trigger channel select and signed threshold
//   m_data/m_valid/m_ready/m_last : snapshot stream
//   busy, done, err        : status (done is a 1-cycle pulse, err is sticky)
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned PRE_SAMPLES = 256
) (
  input  logic        CLKDIV,
  input  logic        RST,
  input  logic        aligned,
  input  logic [15:0] adc1,
  input  logic [15:0] adc2,
  input  logic [15:0] adc4,
  input  logic [15:0] adc8,
  input  logic        arm,
  input  logic        abort,
  input  logic        force_trig,
  input  logic [1:0]  trig_ch,
  input  logic [15:0] trig_lvl,
  output logic [63:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned POST_N = DEPTH - PRE_SAMPLES - 1;
`ifdef ADC_CAPTURE_TIMESTAMP_EN
  localparam int unsigned TOTAL  = DEPTH + 1;
`else
  localparam int unsigned TOTAL  = DEPTH;
`endif
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_SAMPLES - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(POST_N - 1);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_SAMPLES);
  localparam logic [CW-1:0] TOTAL_W   = CW'(TOTAL);
  localparam logic [CW-1:0] LAST_IDX  = CW'(TOTAL - 1);

  cap_state_t state_q, state_d;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;        // prefill / post frame counter
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] iss_q, iss_d;        // words issued into the readout pipe
  frame_t        prev_q, prev_d;
  logic          stg_vld_q, stg_vld_d;   // RAM output stage holds a word
  logic          stg_last_q, stg_last_d;
  logic [63:0]   m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  frame_t        cur;
  logic          capturing, in_ro;
  logic          wr_en, crossing, trig_hit, prefill_done, post_done;
  logic          out_load, issue, ram_re, is_hdr, accept_last;
  logic [63:0]   ram_rdata;

`ifdef ADC_CAPTURE_TIMESTAMP_EN
  logic [47:0]   ts_q, ts_d;
  logic [47:0]   trig_ts_q, trig_ts_d;
  logic          stg_hdr_q, stg_hdr_d;
`endif

  assign cur = {adc8, adc4, adc2, adc1};

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLKDIV or posedge RST) begin
    if (RST) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:     if (arm) state_d = StPrefill;
        StPrefill:  if (!aligned) state_d = StIdle;
                    else if (prefill_done) state_d = StWaitTrig;
        StWaitTrig: if (!aligned) state_d = StIdle;
                    else if (trig_hit) state_d = StPost;
        StPost:     if (!aligned) state_d = StIdle;
                    else if (post_done) state_d = StReadout;
        StReadout:  if (accept_last) state_d = StIdle;
        default:    state_d = StIdle;
      endcase
    end
  end

  // ---------------- FSM: outputs / decodes ----------------
  always_comb begin
    capturing = 1'b0;
    in_ro     = 1'b0;
    unique case (state_q)
      StPrefill, StWaitTrig, StPost: capturing = 1'b1;
      StReadout:                     in_ro     = 1'b1;
      default:                       ;
    endcase
  end

  assign busy    = (state_q != StIdle);
  assign m_valid = m_valid_q & ~abort;  // abort withdraws the word immediately
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign done    = done_q;
  assign err     = err_q;

  assign wr_en        = capturing && aligned && !abort;
  assign crossing     = (sel_ch(prev_q, trig_ch) < $signed(trig_lvl)) &&
                        (sel_ch(cur, trig_ch) >= $signed(trig_lvl));
  assign trig_hit     = (state_q == StWaitTrig) && wr_en && (force_trig || crossing);
  assign prefill_done = (state_q == StPrefill) && wr_en && (cnt_q == PRE_LAST);
  assign post_done    = (state_q == StPost) && wr_en && (cnt_q == POST_LAST);
  assign accept_last  = m_valid && m_ready && m_last_q;

`ifdef ADC_CAPTURE_TIMESTAMP_EN
  assign is_hdr = (iss_q == '0);
`else
  assign is_hdr = 1'b0;
`endif

  // ---------------- Datapath next state ----------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    prev_d     = prev_q;
    rd_ptr_d   = rd_ptr_q;
    err_d      = err_q;
    iss_d      = iss_q;
    stg_vld_d  = stg_vld_q;
    stg_last_d = stg_last_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    out_load   = 1'b0;
    issue      = 1'b0;
    ram_re     = 1'b0;
    done_d     = in_ro && !abort && accept_last;
`ifdef ADC_CAPTURE_TIMESTAMP_EN
    ts_d       = aligned ? ts_q + 48'd1 : ts_q;
    trig_ts_d  = trig_hit ? ts_q : trig_ts_q;
    stg_hdr_d  = stg_hdr_q;
`endif

    // Capture side
    if (state_q == StIdle && arm && !abort) begin
      wr_ptr_d = '0;
      cnt_d    = '0;
      err_d    = 1'b0;
    end
    if (capturing && !abort && !aligned) err_d = 1'b1;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      prev_d   = cur;
      cnt_d    = (state_q == StWaitTrig || prefill_done) ? '0 : cnt_q + 1'b1;
      // Snapshot starts PRE_SAMPLES frames before the trigger frame's address.
      if (trig_hit) rd_ptr_d = wr_ptr_q - PRE_OFS;
    end

    // Readout: RAM output register is stage 1, m_data_q is stage 2.
    if (!in_ro || abort) begin
      iss_d      = '0;
      stg_vld_d  = 1'b0;
      stg_last_d = 1'b0;
      m_valid_d  = 1'b0;
      m_last_d   = 1'b0;
    end else begin
      out_load = stg_vld_q && (!m_valid_q || m_ready);
      issue    = (iss_q != TOTAL_W) && (!stg_vld_q || out_load);
      ram_re   = issue && !is_hdr;
      if (issue) begin
        iss_d      = iss_q + 1'b1;
        stg_vld_d  = 1'b1;
        stg_last_d = (iss_q == LAST_IDX);
`ifdef ADC_CAPTURE_TIMESTAMP_EN
        stg_hdr_d  = is_hdr;
`endif
      end else if (out_load) begin
        stg_vld_d = 1'b0;
      end
      if (ram_re) rd_ptr_d = rd_ptr_q + 1'b1;
      if (out_load) begin
`ifdef ADC_CAPTURE_TIMESTAMP_EN
        m_data_d = stg_hdr_q ? {HDR_MAGIC, trig_ts_q} : ram_rdata;
`else
        m_data_d = ram_rdata;
`endif
        m_valid_d = 1'b1;
        m_last_d  = stg_last_q;
      end else if (m_valid_q && m_ready) begin
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
      end
    end
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge CLKDIV or posedge RST) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      prev_q     <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
      iss_q      <= '0;
      stg_vld_q  <= 1'b0;
      stg_last_q <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      rd_ptr_q   <= rd_ptr_d;
      err_q      <= err_d;
      iss_q      <= iss_d;
      stg_vld_q  <= stg_vld_d;
      stg_last_q <= stg_last_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      done_q     <= done_d;
    end
  end

`ifdef ADC_CAPTURE_TIMESTAMP_EN
  always_ff @(posedge CLKDIV or posedge RST) begin
    if (RST) begin
      ts_q      <= '0;
      trig_ts_q <= '0;
      stg_hdr_q <= 1'b0;
    end else begin
      ts_q      <= ts_d;
      trig_ts_q <= trig_ts_d;
      stg_hdr_q <= stg_hdr_d;
    end
  end
`endif

  capture_ram #(
    .DEPTH(DEPTH),
    .WIDTH(64)
  ) u_ram (
    .clk_i  (CLKDIV),
    .we_i   (wr_en),
    .waddr_i(wr_ptr_q),
    .wdata_i(cur),
    .re_i   (ram_re),
    .raddr_i(rd_ptr_q),
    .rdata_o(ram_rdata)
  );

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture (DEPTH=16, PRE_SAMPLES=4). Expected snapshot
// words are queued while the trigger frame is driven and popped as the DUT
// streams them out.
module tb_adc_capture;

  localparam int DEPTH = 16;
  localparam int PRE   = 4;
  localparam int POSTN = DEPTH - PRE - 1;

  logic        CLKDIV, RST, aligned;
  logic [15:0] adc1, adc2, adc4, adc8;
  logic        arm, abort, force_trig;
  logic [1:0]  trig_ch;
  logic [15:0] trig_lvl;
  logic [63:0] m_data;
  logic        m_valid, m_ready, m_last, busy, done, err;

  typedef struct {
    logic [63:0] d;
    logic        l;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  adc_capture #(
    .DEPTH      (DEPTH),
    .PRE_SAMPLES(PRE)
  ) dut (
    .CLKDIV    (CLKDIV),
    .RST       (RST),
    .aligned   (aligned),
    .adc1      (adc1),
    .adc2      (adc2),
    .adc4      (adc4),
    .adc8      (adc8),
    .arm       (arm),
    .abort     (abort),
    .force_trig(force_trig),
    .trig_ch   (trig_ch),
    .trig_lvl  (trig_lvl),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial CLKDIV = 1'b0;
  always #5 CLKDIV = ~CLKDIV;

`ifdef ADC_CAPTURE_TIMESTAMP_EN
  // Number of aligned clock edges since reset.
  logic [47:0] aln_cnt;
  always @(posedge CLKDIV or posedge RST) begin
    if (RST) aln_cnt <= '0;
    else if (aligned) aln_cnt <= aln_cnt + 48'd1;
  end
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Frame k of a capture: adc2/4/8 tag the frame index, adc1 ramps or is constant.
  function automatic logic [63:0] frm(input int k, input bit ramp1, input logic [15:0] c1);
    logic [15:0] a1;
    a1 = ramp1 ? c1 + 16'(k) : c1;
    return {16'h8000 + 16'(k), 16'h4000 + 16'(k), 16'h2000 + 16'(k), a1};
  endfunction

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge CLKDIV);
    arm = 1'b0;
    #1;
    chk1("busy_after_arm", busy, 1'b1);
    chk1("err_after_arm", err, 1'b0);
  endtask

  // Drive frames k=0.. (k=0 is the first PREFILL cycle); t_idx is the frame
  // expected to trigger. drop_at>=0 deasserts aligned on that frame and stops.
  task automatic capture(input bit ramp1, input logic [15:0] c1, input int t_idx,
                         input bit use_force, input int drop_at);
    exp_t e;
    for (int k = 0; k <= t_idx + POSTN; k++) begin
      {adc8, adc4, adc2, adc1} = frm(k, ramp1, c1);
      // k==1 lands in PREFILL, where force_trig must be ignored.
      force_trig = use_force && (k == t_idx || k == 1);
      aligned    = (k != drop_at);
      if (k == t_idx && drop_at < 0) begin
`ifdef ADC_CAPTURE_TIMESTAMP_EN
        e.d = {16'hA5C0, aln_cnt};
        e.l = 1'b0;
        q.push_back(e);
`endif
        for (int j = 0; j < DEPTH; j++) begin
          e.d = frm(t_idx - PRE + j, ramp1, c1);
          e.l = (j == DEPTH - 1);
          q.push_back(e);
        end
      end
      @(negedge CLKDIV);
      if (k == drop_at) break;
    end
    force_trig = 1'b0;
    aligned    = 1'b1;
  endtask

  // mode 0: ready high, 1: toggle 1-0-1-0, 2: random. abort_at>=0 aborts
  // while that many words have been accepted and the next one is valid.
  task automatic drain(input int mode, input int abort_at);
    int          acc;
    bit          held, seen, fin;
    logic [63:0] hold_d;
    exp_t        e;
    acc = 0; held = 0; seen = 0; fin = 0; hold_d = '0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      #1;
      if (held) begin
        chk1("stall_valid", m_valid, 1'b1);
        chk64("stall_data", m_data, hold_d);
        held = 0;
      end
      if (m_valid && !seen) begin
        seen = 1;
        if (mode == 0) chk64("first_valid_latency", 64'(cyc), 64'd2);
      end
      if (abort_at >= 0 && acc == abort_at && m_valid) begin
        abort = 1'b1;
        #1;
        chk1("abort_valid_now", m_valid, 1'b0);
        @(negedge CLKDIV);
        abort = 1'b0;
        #1;
        chk1("abort_valid_next", m_valid, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        repeat (3) begin
          @(negedge CLKDIV);
          chk1("abort_no_done", done, 1'b0);
        end
        q.delete();
        return;
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          chk64("unexpected_word", m_data, 64'hx);
        end else begin
          e = q.pop_front();
          chk64("word_data", m_data, e.d);
          chk1("word_last", m_last, e.l);
          acc++;
          if (e.l) fin = 1;
        end
      end else if (m_valid) begin
        held   = 1;
        hold_d = m_data;
      end
      @(negedge CLKDIV);
    end
    if (!fin) begin
      chk1("drain_timeout", 1'b0, 1'b1);
      return;
    end
    chk1("done_pulse", done, 1'b1);
    chk1("idle_after_done", busy, 1'b0);
    @(negedge CLKDIV);
    chk1("done_one_cycle", done, 1'b0);
    chk64("queue_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    RST = 1'b1; aligned = 1'b0; arm = 1'b0; abort = 1'b0; force_trig = 1'b0;
    adc1 = '0; adc2 = '0; adc4 = '0; adc8 = '0;
    trig_ch = 2'd0; trig_lvl = '0; m_ready = 1'b1;
    repeat (3) @(negedge CLKDIV);
    chk1("rst_valid", m_valid, 1'b0);
    chk1("rst_last", m_last, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk64("rst_data", m_data, 64'd0);
    RST = 1'b0;
    aligned = 1'b1;
    @(negedge CLKDIV);

    // arm together with abort: abort wins
    arm = 1'b1; abort = 1'b1;
    @(negedge CLKDIV);
    arm = 1'b0; abort = 1'b0;
    #1;
    chk1("arm_abort_idle", busy, 1'b0);
    @(negedge CLKDIV);

    // 1: ramp on adc1, crossing at 10 -> adc1 6..21
    trig_ch = 2'd0; trig_lvl = 16'd10;
    pulse_arm();
    capture(1'b1, 16'd0, 10, 1'b0, -1);
    drain(0, -1);

    // 2: constant trigger channel, force_trig on the second WAIT_TRIG frame
    trig_ch = 2'd0; trig_lvl = 16'd100;
    pulse_arm();
    capture(1'b0, 16'd7, 5, 1'b1, -1);
    drain(0, -1);

    // 3: signed crossing -1 -> 0 on adc1, ready toggling
    trig_ch = 2'd0; trig_lvl = 16'd0;
    pulse_arm();
    capture(1'b1, 16'hFFFA, 6, 1'b0, -1);
    drain(1, -1);

    // 4: aligned dropped 2 cycles into POST, then a clean capture on adc2
    trig_ch = 2'd0; trig_lvl = 16'd10;
    pulse_arm();
    capture(1'b1, 16'd0, 10, 1'b0, 12);
    #1;
    chk1("drop_err", err, 1'b1);
    chk1("drop_busy", busy, 1'b0);
    @(negedge CLKDIV);
    chk1("err_sticky", err, 1'b1);
    trig_ch = 2'd1; trig_lvl = 16'h2008;
    pulse_arm();
    capture(1'b0, 16'd7, 8, 1'b0, -1);
    drain(2, -1);

    // 5: abort on the third readout word, then a clean capture
    trig_ch = 2'd2; trig_lvl = 16'h400B;
    pulse_arm();
    capture(1'b0, 16'd7, 11, 1'b0, -1);
    drain(0, 2);
    trig_ch = 2'd0; trig_lvl = 16'd10;
    pulse_arm();
    capture(1'b1, 16'd0, 10, 1'b0, -1);
    drain(0, -1);

`ifdef ADC_CAPTURE_TIMESTAMP_EN
    // 6: 20 aligned idle cycles before arm; header carries the trigger count
    repeat (20) @(negedge CLKDIV);
    pulse_arm();
    capture(1'b1, 16'd0, 10, 1'b0, -1);
    drain(0, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
